// File: rtl/uart_rx.sv
// uart_rx: oversampling-counter UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 (8E1)
// and to expose the parity_err_o pulse output.
// The line is double-flopped; only the second flop (rx_s) feeds the FSM.
module uart_rx #(
  parameter int CLOCKS_PER_BAUD = 1250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  // Counter reloads; both fit in CW bits, and the counter only ever
  // decrements while non-zero, so it cannot wrap.
  localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
`endif

  assign rx_s   = sync[1];
  assign busy_o = (state != IDLE);

  // Synchronizer plus receive FSM; pulse outputs default low every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync        <= 2'b11;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      sync        <= {sync[0], rx_i};
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF;
            state <= START;
          end
        end
        // Half a bit later: still low means a real start bit, else a glitch.
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_s) begin
            cnt     <= FULL;
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        // Even parity: data bits XOR parity bit must be zero.
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            par_bad <= rx_s ^ (^shreg);
            cnt     <= FULL;
            state   <= STOP;
          end
        end
`endif
        // Return to IDLE mid stop bit so a back-to-back start edge is caught.
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              parity_err_o <= 1'b1;
            end else begin
              data_o  <= shreg;
              valid_o <= 1'b1;
            end
`else
            data_o  <= shreg;
            valid_o <= 1'b1;
`endif
            state <= IDLE;
          end else begin
            frame_err_o <= 1'b1;
            state       <= WAIT_HIGH;
          end
        end
        // A held-low line (break) reports once, then waits for idle.
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with hand-computed expectations.
// A small CLOCKS_PER_BAUD keeps the run short; latency is checked against
// the closed-form formula.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Edges from the first edge that captures the falling start edge to the
  // edge that raises valid_o.
  localparam int LAT = 2 + H + (NBITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, busy, perr;

  uart_rx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .data_o(data), .valid_o(valid),
    .frame_err_o(ferr),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(perr),
`endif
    .busy_o(busy));
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_excl = 0;
  int last_valid_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] rx_q[$];
  int n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      rx_q.push_back(data);
      last_valid_cyc = cyc;
    end
    if (ferr) n_ferr++;
    if (perr) n_perr++;
    if (int'(valid) + int'(ferr) + int'(perr) > 1) n_excl++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Data bits LSB first, optional parity (flip to corrupt), then stop bit.
  task automatic send_body(input logic [7:0] d, input logic par_flip, input logic stop);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    fall_cyc = cyc;
    send_bit(1'b0);
    send_body(d, par_flip, stop);
  endtask

  int v0, f0, p0, q0;
  task automatic snap();
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; q0 = rx_q.size();
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_perr", perr, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    // Single byte 0x41 with latency
    snap();
    send_frame(8'h41, 1'b0, 1'b1);
    tick(CPB);
    chk("b41_count", n_valid - v0, 1);
    chk("b41_data", data, 8'h41);
    chk("b41_latency", last_valid_cyc - fall_cyc - 1, LAT);
    chk("b41_busy", busy, 0);
    chk("b41_ferr", n_ferr - f0, 0);

    // Short low glitch: rejected at the mid-start-bit check
    snap();
    rx = 1'b0;
    tick(5);
    chk("glitch_busy_hi", busy, 1);
    rx = 1'b1;
    tick(2 * CPB);
    chk("glitch_valid", n_valid - v0, 0);
    chk("glitch_ferr", n_ferr - f0, 0);
    chk("glitch_idle", busy, 0);

    // Bad stop bit then break, then a good frame
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    tick(5000);
    chk("brk_ferr_once", n_ferr - f0, 1);
    chk("brk_no_valid", n_valid - v0, 0);
    chk("brk_data_hold", data, 8'h41);
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    tick(CPB);
    chk("brk_idle", busy, 0);
    send_frame(8'h33, 1'b0, 1'b1);
    tick(CPB);
    chk("brk_33_count", n_valid - v0, 1);
    chk("brk_33_data", data, 8'h33);
    chk("brk_ferr_total", n_ferr - f0, 1);

    // Reset during bit 4 of 0x7E, line then idles, then 0xA5
    snap();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    rx = 1'b1;
    tick(H);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick(12 * CPB);
    chk("mid_rst_no_valid", n_valid - v0, 0);
    chk("mid_rst_no_ferr", n_ferr - f0, 0);
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(CPB);
    chk("a5_count", n_valid - v0, 1);
    chk("a5_data", data, 8'hA5);

    // Line already low when reset releases: start bit still accepted
    snap();
    rst = 1'b1;
    rx  = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(CPB - 2);
    send_body(8'h96, 1'b0, 1'b1);
    tick(CPB);
    chk("rel_low_count", n_valid - v0, 1);
    chk("rel_low_data", data, 8'h96);

    // 'A'..'Z' back to back, twice
    snap();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 26; c++) send_frame(8'h41 + 8'(c), 1'b0, 1'b1);
    tick(CPB);
    chk("az_count", n_valid - v0, 52);
    chk("az_ferr", n_ferr - f0, 0);
    for (int i = 0; i < 52; i++)
      if (q0 + i < rx_q.size()) chk($sformatf("az_byte%0d", i), rx_q[q0 + i], 8'h41 + 8'(i % 26));

`ifdef UART_RX_PARITY_EN
    // Good parity, bad parity, then bad parity with bad stop bit
    snap();
    send_frame(8'h41, 1'b0, 1'b1);
    tick(CPB);
    chk("par_ok_valid", n_valid - v0, 1);
    chk("par_ok_data", data, 8'h41);
    snap();
    send_frame(8'h41, 1'b1, 1'b1);
    tick(CPB);
    chk("par_bad_perr", n_perr - p0, 1);
    chk("par_bad_valid", n_valid - v0, 0);
    chk("par_bad_data", data, 8'h41);
    snap();
    send_frame(8'h42, 1'b1, 1'b0);
    tick(2 * CPB);
    chk("par_stop_ferr", n_ferr - f0, 1);
    chk("par_stop_perr", n_perr - p0, 0);
    chk("par_stop_data", data, 8'h41);
`endif

    chk("exclusive_pulses", n_excl, 0);
    chk("no_stray_perr", n_perr - p0, `ifdef UART_RX_PARITY_EN 0 `else 0 `endif);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 1250, giving clk_i cycles per bit (9600 baud at 12 MHz); legal range >= 4.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port rx_i, input, 1: asynchronous serial line, idle high, 8N1 (8E1 with REQ-024).
REQ-005 SHALL have port data_o, output, 8: last good received byte.
REQ-006 SHALL have port valid_o, output, 1: single-cycle pulse marking a new byte on data_o.
REQ-007 SHALL have port frame_err_o, output, 1: single-cycle pulse when a stop bit is sampled low.
REQ-008 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-009 SHALL pass rx_i through a two-flop synchronizer; the FSM SHALL use only the second flop (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (present only with REQ-024), STOP and WAIT_HIGH.
REQ-011 IDLE: when rx_s==0, SHALL load the bit counter with CLOCKS_PER_BAUD/2-1 (integer division) and enter START.
REQ-012 START: on counter==0, SHALL sample rx_s; if 0, load CLOCKS_PER_BAUD-1, clear bit index, enter DATA; if 1, treat as a glitch and return to IDLE with no output pulse.
REQ-013 DATA: on each counter==0, SHALL shift rx_s into the shift register LSB-first, reload CLOCKS_PER_BAUD-1, and after the 8th bit enter STOP (PARITY with REQ-024).
REQ-014 STOP: on counter==0, if rx_s==1, SHALL copy the shift register to data_o, pulse valid_o for exactly one cycle and enter IDLE immediately (mid stop bit) so back-to-back frames are received.
REQ-015 STOP: on counter==0, if rx_s==0, SHALL pulse frame_err_o for one cycle, leave data_o unchanged and enter WAIT_HIGH.
REQ-016 WAIT_HIGH: SHALL remain until rx_s==1, then enter IDLE; a held-low line (break) SHALL produce exactly one frame_err_o pulse.
REQ-017 valid_o SHALL rise on the clock edge following the stop-bit sample: nominally 2 + CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD cycles after rx_i falls (+1 period with REQ-024).
REQ-018 There SHALL be no backpressure; data_o SHALL hold its value until the next valid frame and may be read at any later time.
REQ-019 valid_o, frame_err_o and parity_err_o SHALL be mutually exclusive in any cycle.
REQ-020 The bit counter SHALL be $clog2(CLOCKS_PER_BAUD) bits wide and SHALL never underflow or wrap.

Reset
REQ-021 While rst_i is high at a clock edge: state SHALL be IDLE; synchronizer flops SHALL be 1; data_o SHALL be 8'h00; valid_o, frame_err_o, parity_err_o and busy_o SHALL be 0.
REQ-022 Reset mid-frame SHALL discard the partial byte with no output pulse; reception SHALL resume on the first falling edge after rst_i deasserts.
REQ-023 If rx_i is low when reset releases, the block SHALL enter START and apply REQ-012 as normal.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, the block SHALL expect an even-parity bit after bit 7, sampled in the PARITY state, and SHALL provide output port parity_err_o (1 bit).
REQ-025 With UART_RX_PARITY_EN defined, on a parity mismatch the block SHALL still sample the stop bit. If the stop bit is good, it SHALL pulse parity_err_o instead of valid_o and leave data_o unchanged. If the stop bit is bad, REQ-015 SHALL take priority.
REQ-026 Without UART_RX_PARITY_EN, the block SHALL have neither the PARITY state nor the parity_err_o port, and frames SHALL be 8N1.

Verification
REQ-027 Stimulus: 8N1 byte 0x41 at CLOCKS_PER_BAUD=1250. Response: one valid_o pulse with data_o==0x41 at the latency given in REQ-017, and busy_o low afterwards.
REQ-028 Stimulus: drive the line from the existing 10 Hz uart_tx test pattern 'A'..'Z' through the synchronizer. Response: 26 valid_o pulses carrying 0x41..0x5A in order, repeating, with no frame_err_o.
REQ-029 Stimulus: a 300-cycle low glitch on an idle line. Response: no valid_o, no frame_err_o, return to IDLE.
REQ-030 Stimulus: byte 0x55 with a low stop bit, then the line held low 5000 cycles, then high, then 0x33. Response: exactly one frame_err_o pulse, data_o unchanged, then valid_o pulse with data_o==0x33.
REQ-031 Stimulus: rst_i pulsed during bit 4 of 0x7E, then 0xA5 sent. Response: no pulse for 0x7E; valid_o pulse with data_o==0xA5.
REQ-032 Stimulus (UART_RX_PARITY_EN): 0x41 sent with parity bit 0, then 0x41 sent with parity bit 1. Response: valid_o pulse with data_o==0x41 for the first frame; one parity_err_o pulse and no valid_o for the second.
